// File: rtl/paddle_motion_ctrl.sv
// Pong paddle motion sequencer: turns up/down button levels into per-frame
// paddle position updates with speed ramp, wall clamping and recentring.
// Position, speed and state only change on the frame tick, so the renderer
// never sees a paddle that moves mid-frame.
module paddle_motion_ctrl #(
  parameter int X_POS      = 20,
  parameter int WIDTH      = 8,
  parameter int HEIGHT     = 48,
  parameter int Y_MIN      = 8,
  parameter int Y_MAX      = 472,
  parameter int Y_RESET    = 216,
  parameter int V_MAX      = 8,
  parameter int ACC_FRAMES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       center_req,
  output logic [9:0] x_paddle,
  output logic [9:0] y_paddle,
  output logic [7:0] width_paddle,
  output logic [7:0] height_paddle,
  output logic [3:0] speed,
  output logic       busy_center
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_MOVE_UP   = 2'd1,
    S_MOVE_DOWN = 2'd2,
    S_CENTER    = 2'd3
  } state_t;

  // Motion arithmetic is done on 11-bit signed values so that neither the
  // subtraction near the top wall nor the addition near the bottom wraps.
  localparam logic signed [10:0] Y_LO_S   = 11'(Y_MIN);
  localparam logic signed [10:0] Y_HI_S   = 11'(Y_MAX - HEIGHT);
  localparam logic signed [10:0] Y_RST_S  = 11'(Y_RESET);
  localparam logic signed [10:0] V_MAX_S  = 11'(V_MAX);
  localparam logic [9:0]         Y_RST10  = 10'(Y_RESET);
  localparam logic [3:0]         V_MAX4   = 4'(V_MAX);
  localparam logic [3:0]         ACC_LAST = 4'(ACC_FRAMES - 1);

  state_t     state_q, state_d;
  logic [9:0] y_q, y_d;
  logic [3:0] speed_q, speed_d;
  logic [3:0] hold_q, hold_d;
  logic       pend_q, pend_d;
  logic       up_meta_q, up_meta_d, up_sync_q, up_sync_d;
  logic       dn_meta_q, dn_meta_d, dn_sync_q, dn_sync_d;

  logic       dir_up, dir_dn;
  logic [3:0] hold_inc;
  logic [9:0] y_ctr;

  // Move up by s pixels, stopping at the top wall.
  function automatic logic [9:0] step_up(input logic [9:0] y, input logic [3:0] s);
    logic signed [10:0] t;
    t = $signed({1'b0, y}) - $signed({7'd0, s});
    step_up = (t < Y_LO_S) ? Y_LO_S[9:0] : t[9:0];
  endfunction

  // Move down by s pixels, stopping where the paddle bottom meets the wall.
  function automatic logic [9:0] step_dn(input logic [9:0] y, input logic [3:0] s);
    logic signed [10:0] t;
    t = $signed({1'b0, y}) + $signed({7'd0, s});
    step_dn = (t > Y_HI_S) ? Y_HI_S[9:0] : t[9:0];
  endfunction

  // Move toward the centre by at most V_MAX, landing exactly on it.
  function automatic logic [9:0] center_step(input logic [9:0] y);
    logic signed [10:0] ys;
    logic signed [10:0] diff;
    logic signed [10:0] mag;
    logic signed [10:0] res;
    ys   = $signed({1'b0, y});
    diff = ys - Y_RST_S;
    mag  = diff[10] ? -diff : diff;
    mag  = (mag > V_MAX_S) ? V_MAX_S : mag;
    res  = diff[10] ? (ys + mag) : (ys - mag);
    center_step = res[9:0];
  endfunction

  // Next-state, speed ramp, motion and centre-pending logic.
  always_comb begin
    up_meta_d = btn_up;
    up_sync_d = up_meta_q;
    dn_meta_d = btn_down;
    dn_sync_d = dn_meta_q;
    dir_up    = up_sync_q & ~dn_sync_q;
    dir_dn    = dn_sync_q & ~up_sync_q;
    state_d   = state_q;
    y_d       = y_q;
    speed_d   = speed_q;
    hold_d    = hold_q;
    hold_inc  = (hold_q == ACC_LAST) ? 4'd0 : (hold_q + 4'd1);
    y_ctr     = center_step(y_q);

    // A request is consumed by the tick; requests during recentring are dropped.
    if (frame_tick) begin
      pend_d = 1'b0;
    end else if (state_q == S_CENTER) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q | center_req;
    end

    if (frame_tick) begin
      if ((state_q == S_CENTER) || pend_q || center_req) begin
        y_d    = y_ctr;
        hold_d = 4'd0;
        if (y_ctr == Y_RST10) begin
          state_d = S_IDLE;
          speed_d = 4'd0;
        end else begin
          state_d = S_CENTER;
          speed_d = V_MAX4;
        end
      end else if (!enable || !(dir_up || dir_dn)) begin
        state_d = S_IDLE;
        speed_d = 4'd0;
        hold_d  = 4'd0;
      end else begin
        if ((dir_up && (state_q == S_MOVE_UP)) || (dir_dn && (state_q == S_MOVE_DOWN))) begin
          // Same direction held: speed steps up each time the hold count
          // lands on ACC_FRAMES-1, and the move already uses the new speed.
          hold_d  = hold_inc;
          speed_d = ((hold_inc == ACC_LAST) && (speed_q < V_MAX4)) ? (speed_q + 4'd1) : speed_q;
        end else begin
          state_d = dir_up ? S_MOVE_UP : S_MOVE_DOWN;
          speed_d = 4'd1;
          hold_d  = 4'd0;
        end
        y_d = dir_up ? step_up(y_q, speed_d) : step_dn(y_q, speed_d);
      end
    end else begin
      state_d = state_q;
      y_d     = y_q;
    end
  end

  // State, position, speed and button synchronizer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      y_q       <= Y_RST10;
      speed_q   <= 4'd0;
      hold_q    <= 4'd0;
      pend_q    <= 1'b0;
      up_meta_q <= 1'b0;
      up_sync_q <= 1'b0;
      dn_meta_q <= 1'b0;
      dn_sync_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      speed_q   <= speed_d;
      hold_q    <= hold_d;
      pend_q    <= pend_d;
      up_meta_q <= up_meta_d;
      up_sync_q <= up_sync_d;
      dn_meta_q <= dn_meta_d;
      dn_sync_q <= dn_sync_d;
    end
  end

  assign x_paddle      = 10'(X_POS);
  assign width_paddle  = 8'(WIDTH);
  assign height_paddle = 8'(HEIGHT);
  assign y_paddle      = y_q;
  assign speed         = speed_q;
  assign busy_center   = (state_q == S_CENTER);

endmodule

// File: tb/tb_paddle_motion_ctrl.sv
// Bench for paddle_motion_ctrl: directed stimulus, a frame-level reference
// model compared every cycle, and literal checkpoints from hand calculation.
module tb_paddle_motion_ctrl;

  localparam int YRST = 216;
  localparam int YLO  = 8;
  localparam int YHI  = 472 - 48;
  localparam int VMAX = 8;
  localparam int ACC  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       enable = 1'b1;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       center_req = 1'b0;
  logic [9:0] x_paddle;
  logic [9:0] y_paddle;
  logic [7:0] width_paddle;
  logic [7:0] height_paddle;
  logic [3:0] speed;
  logic       busy_center;

  int total = 0;
  int bad   = 0;

  paddle_motion_ctrl dut (
    .clk(clk), .reset(rst), .frame_tick(frame_tick), .enable(enable),
    .btn_up(btn_up), .btn_down(btn_down), .center_req(center_req),
    .x_paddle(x_paddle), .y_paddle(y_paddle), .width_paddle(width_paddle),
    .height_paddle(height_paddle), .speed(speed), .busy_center(busy_center)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame-level) ----------------
  // mode: 0 idle, 1 moving up, 2 moving down, 3 recentring
  int m_y = YRST, m_spd = 0, m_mode = 0, m_n = 0, m_step = 0, m_dist = 0, m_dir = 0;
  bit m_pend = 1'b0;
  bit uh1 = 1'b0, uh2 = 1'b0, dh1 = 1'b0, dh2 = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_y = YRST; m_spd = 0; m_mode = 0; m_n = 0; m_pend = 1'b0;
      uh1 = 1'b0; uh2 = 1'b0; dh1 = 1'b0; dh2 = 1'b0;
    end else begin
      // Buttons are seen by the controller two clock edges after sampling.
      m_dir = (uh2 && !dh2) ? 1 : ((dh2 && !uh2) ? 2 : 0);
      uh2 = uh1; uh1 = btn_up;
      dh2 = dh1; dh1 = btn_down;
      if (frame_tick) begin
        if (m_mode == 3 || m_pend || center_req) begin
          m_dist = m_y - YRST;
          m_step = (m_dist < 0) ? -m_dist : m_dist;
          if (m_step > VMAX) m_step = VMAX;
          m_y    = (m_dist < 0) ? m_y + m_step : m_y - m_step;
          m_mode = (m_y == YRST) ? 0 : 3;
          m_spd  = (m_mode == 3) ? VMAX : 0;
          m_pend = 1'b0;
        end else if (!enable || m_dir == 0) begin
          m_mode = 0; m_spd = 0;
        end else begin
          if (m_dir == m_mode) m_n = m_n + 1;
          else begin m_mode = m_dir; m_n = 0; end
          // Speed 1 on entry, first step after ACC-1 held frames, then every ACC.
          m_spd = (m_n == 0) ? 1 : 1 + (m_n + 1) / ACC;
          if (m_spd > VMAX) m_spd = VMAX;
          if (m_dir == 1) m_y = (m_y - m_spd < YLO) ? YLO : m_y - m_spd;
          else            m_y = (m_y + m_spd > YHI) ? YHI : m_y + m_spd;
        end
      end else if (m_mode != 3 && center_req) begin
        m_pend = 1'b1;
      end
    end
  end

  // Compare DUT against the model shortly after every active edge.
  always @(posedge clk) begin
    #2;
    chk("y_model",     int'(y_paddle),      m_y);
    chk("speed_model", int'(speed),         m_spd);
    chk("busy_model",  int'(busy_center),   (m_mode == 3) ? 1 : 0);
    chk("x_const",     int'(x_paddle),      20);
    chk("w_const",     int'(width_paddle),  8);
    chk("h_const",     int'(height_paddle), 48);
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick();
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    idle(2);
  endtask

  int exp_spd [10] = '{1, 1, 1, 2, 2, 2, 2, 3, 3, 3};

  initial begin
    #1000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    rst = 1'b0;
    chk("rst_y", int'(y_paddle), 216);
    chk("rst_speed", int'(speed), 0);
    chk("rst_busy", int'(busy_center), 0);

    // Idle frames: nothing moves.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_y", int'(y_paddle), 216);
      chk("idle_speed", int'(speed), 0);
      chk("idle_busy", int'(busy_center), 0);
    end

    // Hold up for 10 frames: speed ramp 1,1,1,2,2,2,2,3,3,3.
    btn_up = 1'b1; idle(2);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("ramp_speed", int'(speed), exp_spd[i]);
    end
    chk("ramp_y", int'(y_paddle), 196);

    // Reverse to down and hold until the bottom wall clamps.
    btn_up = 1'b0; btn_down = 1'b1; idle(2);
    tick();
    chk("rev_speed", int'(speed), 1);
    chk("rev_y", int'(y_paddle), 197);
    for (int i = 0; i < 44; i++) tick();
    chk("clamp_y", int'(y_paddle), 424);
    chk("clamp_speed", int'(speed), 8);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("clamp_hold_y", int'(y_paddle), 424);
      chk("clamp_hold_speed", int'(speed), 8);
    end

    // Up three frames, then both buttons, then release one.
    btn_down = 1'b0; btn_up = 1'b1; idle(2);
    for (int i = 0; i < 3; i++) tick();
    chk("up3_y", int'(y_paddle), 421);
    btn_down = 1'b1; idle(2);
    tick();
    chk("both_speed", int'(speed), 0);
    chk("both_y", int'(y_paddle), 421);
    btn_down = 1'b0; idle(2);
    tick();
    chk("restart_speed", int'(speed), 1);
    chk("restart_y", int'(y_paddle), 420);

    // Drive to the top wall.
    for (int i = 0; i < 70; i++) tick();
    chk("top_y", int'(y_paddle), 8);

    // Recentre with the game disabled; buttons must be ignored.
    enable = 1'b0; btn_up = 1'b0;
    @(negedge clk); center_req = 1'b1;
    @(negedge clk); center_req = 1'b0;
    btn_down = 1'b1;
    chk("pend_busy", int'(busy_center), 0);
    for (int k = 1; k <= 26; k++) begin
      if (k == 10) begin
        @(negedge clk); center_req = 1'b1;
        @(negedge clk); center_req = 1'b0;
      end
      tick();
      chk("ctr_y", int'(y_paddle), 8 + 8 * k);
      chk("ctr_busy", int'(busy_center), (k < 26) ? 1 : 0);
      chk("ctr_speed", int'(speed), (k < 26) ? 8 : 0);
    end
    tick();
    chk("ctr_after_y", int'(y_paddle), 216);

    // Button change one cycle before the tick is not yet visible.
    btn_down = 1'b0; enable = 1'b1; idle(3);
    @(negedge clk); btn_down = 1'b1;
    tick();
    chk("sync_y", int'(y_paddle), 216);
    chk("sync_speed", int'(speed), 0);
    tick();
    chk("sync2_y", int'(y_paddle), 217);
    for (int i = 0; i < 5; i++) tick();
    chk("down5_y", int'(y_paddle), 225);

    // Centre request coincident with the tick takes effect on that tick.
    @(negedge clk); frame_tick = 1'b1; center_req = 1'b1;
    @(negedge clk); frame_tick = 1'b0; center_req = 1'b0;
    chk("coinc_y", int'(y_paddle), 217);
    chk("coinc_busy", int'(busy_center), 1);
    chk("coinc_speed", int'(speed), 8);

    // Asynchronous reset in the middle of the low clock phase.
    #1 rst = 1'b1;
    #1;
    chk("arst_y", int'(y_paddle), 216);
    chk("arst_speed", int'(speed), 0);
    chk("arst_busy", int'(busy_center), 0);
    idle(2);
    rst = 1'b0; btn_down = 1'b0;
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/paddle_motion_ctrl.md
Name: paddle_motion_ctrl

Overview:
- Sequences one Pong paddle: converts up/down button levels into per-frame paddle position updates, with speed ramp, field clamping and a return-to-centre mode.
- Drives the position and size inputs of the display paddle renderer.
- Sits between the input/debounce layer and the display controller.
- Position changes only on the frame tick, so the renderer never sees a paddle that moves mid-frame.

Parameters:
- X_POS, 20, fixed left x coordinate of the paddle (pixels).
- WIDTH, 8, paddle width (pixels).
- HEIGHT, 48, paddle height (pixels).
- Y_MIN, 8, minimum allowed y_paddle (top wall).
- Y_MAX, 472, maximum allowed y_paddle + HEIGHT (bottom wall).
- Y_RESET, 216, centre position and reset value of y_paddle.
- V_MAX, 8, maximum speed in pixels per frame (1..15).
- ACC_FRAMES, 4, held frames per +1 speed step (1..15).

Ports:
- clk  in  1  system pixel clock
- reset  in  1  asynchronous, active-high reset
- frame_tick  in  1  single-cycle pulse, once per frame (start of vertical blanking)
- enable  in  1  game running; low freezes button motion
- btn_up  in  1  level, asynchronous to clk
- btn_down  in  1  level, asynchronous to clk
- center_req  in  1  single-cycle pulse: move paddle back to Y_RESET
- x_paddle  out  10  constant X_POS
- y_paddle  out  10  registered top edge of paddle
- width_paddle  out  8  constant WIDTH
- height_paddle  out  8  constant HEIGHT
- speed  out  4  current speed, pixels/frame
- busy_center  out  1  high while in the CENTER state

Behaviour:
- Reset (async, reset=1) forces:
  - y_paddle=Y_RESET, speed=0, busy_center=0, state=IDLE, hold counter=0, centre-pending=0.
  - x/width/height are constants at all times.
- btn_up and btn_down each pass through a 2-FF synchronizer (2-cycle latency) before use.
- Direction decode (synchronized values):
  - up only → UP; down only → DOWN.
  - both or neither → NONE.
- center_req is latched into centre-pending on any cycle. It is consumed at the next frame_tick.
- All state, speed and y_paddle updates occur only in the cycle frame_tick=1. The new y_paddle is visible the cycle after. Between ticks, outputs hold.
- States: IDLE, MOVE_UP, MOVE_DOWN, CENTER.
- On frame_tick, priority: centre-pending > enable=0 > button direction.
  - centre-pending: go to CENTER, clear pending, speed=V_MAX. This is honoured even when enable=0.
  - enable=0 (not in CENTER): state=IDLE, speed=0, hold counter=0, y_paddle unchanged.
  - IDLE and direction UP/DOWN: go to MOVE_UP/MOVE_DOWN, speed=1, hold=0, move 1 pixel in the same tick.
  - MOVE_x and same direction held: hold counter increments. When it reaches ACC_FRAMES-1 it wraps to 0 and speed=min(speed+1, V_MAX). The move uses the updated speed.
  - MOVE_x and opposite direction: switch state, speed=1, hold=0.
  - MOVE_x and NONE: go to IDLE, speed=0.
- Motion arithmetic uses 11-bit signed intermediates, with no wrap-around:
  - UP: y_new = max(y − speed, Y_MIN).
  - DOWN: y_new = min(y + speed, Y_MAX − HEIGHT).
  - Reaching a wall keeps the MOVE state and speed; y stays at the clamp value.
- CENTER state:
  - Each tick, y moves toward Y_RESET by min(V_MAX, |y − Y_RESET|).
  - Buttons and enable are ignored.
  - On reaching Y_RESET: go to IDLE, speed=0.
  - busy_center=1 exactly while state=CENTER.
  - A new center_req while in CENTER is absorbed.
- A frame_tick coincident with center_req counts as pending for that same tick.
- Reset asserted mid-move or mid-centre returns all outputs to their reset values immediately (async).

Test Plan:
- Reset, then idle for 3 frames → y_paddle=216, speed=0, busy_center=0 throughout.
- Hold btn_up 10 frames from y=216 (ACC_FRAMES=4):
  - speed sequence per tick is 1,1,1,2,2,2,2,3,3,3.
  - y_paddle after tick 10 is 216−20=196.
- Hold btn_down from y=420, speed 8 → y clamps at 424 (472−48) and stays 424 on later ticks; state remains MOVE_DOWN.
- Both buttons high while in MOVE_UP → next tick IDLE, speed=0, y unchanged. Releasing one button → speed restarts at 1.
- center_req at y=8 with enable=0:
  - busy_center=1 from the next tick.
  - y goes 16,24,…,208,216 (26 ticks), then IDLE, busy_center=0.
  - Buttons pressed meanwhile have no effect.
- Toggle btn_down 1 cycle before frame_tick → no movement that tick (synchronizer latency). Assert reset mid-CENTER → y_paddle=216, speed=0 asynchronously.
